// File: rtl/dispatch_steer_pkg.sv
// Shared types for the dispatch steering stage.
// Entry layout and FU class encodings.
package dispatch_steer_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int NUM_CLASSES  = 4;
  localparam int CLASS_BITS   = $clog2(NUM_CLASSES);

  typedef enum logic [CLASS_BITS-1:0] {
    FU_ALU,
    FU_LSU,
    FU_BR,
    FU_MUL
  } fu_class_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                 id;
    logic [31:0]                             instr;
    logic [63:0]                             pc;
    fu_class_t                               fu_class;
    logic [MAX_OPERANDS-1:0]                 op_valid;
    logic [MAX_OPERANDS-1:0]                 op_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   op_prn;
    logic [MAX_OPERANDS-1:0]                 out_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   out_prn;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_steer_rr_arbiter.sv
// Round-robin pick: first request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dispatch_steer.sv
// In-order dispatch buffer steering the head entry
// to a ready issue queue of the matching FU class.
module dispatch_steer
  import dispatch_steer_pkg::*;
#(
  parameter int FU_COUNT = 4,
  parameter int FU_CLASS [FU_COUNT] = '{0, 1, 2, 3},
  parameter int BUF_DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [INST_ID_BITS-1:0]                 in_inst_id,
  input  logic [31:0]                             in_raw_instr,
  input  logic [63:0]                             in_pc,
  input  logic [CLASS_BITS-1:0]                   in_fu_class,
  input  logic [MAX_OPERANDS-1:0]                 in_prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                 in_prn_input_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn_input,
  input  logic [MAX_OPERANDS-1:0]                 in_prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]   set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  input  logic [FU_COUNT-1:0]                     iq_queue_ready,
  output logic [FU_COUNT-1:0]                     iq_inst_valid,
  output logic [INST_ID_BITS-1:0]                 iq_inst_id,
  output logic [31:0]                             iq_raw_instr,
  output logic [63:0]                             iq_pc,
  output logic [MAX_OPERANDS-1:0]                 iq_prn_input_valid,
  output logic [MAX_OPERANDS-1:0]                 iq_prn_input_ready,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   iq_prn_input,
  output logic [MAX_OPERANDS-1:0]                 iq_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   iq_prn_output,
  output logic [31:0]                             stall_cycles,
  output logic                                    err_no_fu
);

  localparam int FU_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);

  dispatch_entry_t         mem [BUF_DEPTH];
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W:0]          count;
  logic [FU_W-1:0]         rr_ptr [NUM_CLASSES];

  dispatch_entry_t         head_e;
  dispatch_entry_t         push_e;
  logic                    head_valid;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    no_fu;
  logic [FU_COUNT-1:0]     cls_hit;
  logic [FU_COUNT-1:0]     req;
  logic [FU_COUNT-1:0]     gnt;
  logic [FU_W-1:0]         gnt_idx;
  logic [FU_W-1:0]         rr_next;
  logic                    gnt_any;
  logic [MAX_OPERANDS-1:0] wake_mem [BUF_DEPTH];
  logic [MAX_OPERANDS-1:0] wake_in;

  function automatic logic hit(
    input logic [PRN_BITS-1:0] prn,
    input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] rdy,
    input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] tag
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < FU_COUNT; k++)
      for (int m = 0; m < MAX_OPERANDS; m++)
        if (rdy[k][m] && tag[k][m] == prn) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    wake_in = '0;
    for (int b = 0; b < BUF_DEPTH; b++) wake_mem[b] = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      wake_in[j] = in_prn_input_valid[j] &&
                   hit(in_prn_input[j], set_prn_ready, set_prn);
      for (int b = 0; b < BUF_DEPTH; b++)
        wake_mem[b][j] = mem[b].op_valid[j] &&
                         hit(mem[b].op_prn[j], set_prn_ready, set_prn);
    end
  end

  always_comb begin
    push_e           = '0;
    push_e.id        = in_inst_id;
    push_e.instr     = in_raw_instr;
    push_e.pc        = in_pc;
    push_e.fu_class  = fu_class_t'(in_fu_class);
    push_e.op_valid  = in_prn_input_valid;
    push_e.op_ready  = (in_prn_input_ready & in_prn_input_valid) | wake_in;
    push_e.op_prn    = in_prn_input;
    push_e.out_valid = in_prn_output_valid;
    push_e.out_prn   = in_prn_output;
  end

  assign head_e     = mem[head];
  assign head_valid = (count != '0);
  assign full       = (count == (PTR_W+1)'(BUF_DEPTH));
  assign in_ready   = !full && !flush;
  assign push       = in_valid && in_ready;

  always_comb begin
    cls_hit = '0;
    for (int f = 0; f < FU_COUNT; f++)
      cls_hit[f] = (FU_CLASS[f] == int'(head_e.fu_class));
  end

  assign req   = cls_hit & iq_queue_ready & {FU_COUNT{head_valid}};
  assign no_fu = head_valid && !(|cls_hit);

  rr_arbiter #(.N(FU_COUNT), .W(FU_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr[head_e.fu_class]),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign pop     = head_valid && gnt_any && !flush;
  assign rr_next = (gnt_idx == FU_W'(FU_COUNT - 1)) ? '0 : gnt_idx + 1'b1;

  assign iq_inst_valid       = pop ? gnt : '0;
  assign iq_inst_id          = head_valid ? head_e.id : '0;
  assign iq_raw_instr        = head_valid ? head_e.instr : '0;
  assign iq_pc               = head_valid ? head_e.pc : '0;
  assign iq_prn_input_valid  = head_valid ? head_e.op_valid : '0;
  assign iq_prn_input        = head_valid ? head_e.op_prn : '0;
  assign iq_prn_output_valid = head_valid ? head_e.out_valid : '0;
  assign iq_prn_output       = head_valid ? head_e.out_prn : '0;
  // Queue ignores wakeups landing with the insert, so forward them here
  assign iq_prn_input_ready  = head_valid ?
    (head_e.op_ready | wake_mem[head]) & head_e.op_valid : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_cycles <= '0;
      err_no_fu    <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) rr_ptr[c] <= '0;
      for (int b = 0; b < BUF_DEPTH; b++) mem[b] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int b = 0; b < BUF_DEPTH; b++)
        mem[b].op_ready <= mem[b].op_ready | wake_mem[b];
      if (push) begin
        mem[tail] <= push_e;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head                    <= head + 1'b1;
        rr_ptr[head_e.fu_class] <= rr_next;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (no_fu) err_no_fu <= 1'b1;
      if (head_valid && !pop && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_steer.sv
// Directed bench: two instances with different
// FU class maps share one stimulus stream.
module tb_dispatch_steer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [5:0] in_inst_id = '0;
  logic [31:0] in_raw_instr = '0;
  logic [63:0] in_pc = '0;
  logic [1:0] in_fu_class = '0;
  logic [2:0] in_prn_input_valid = '0;
  logic [2:0] in_prn_input_ready = '0;
  logic [2:0][5:0] in_prn_input = '0;
  logic [2:0] in_prn_output_valid = '0;
  logic [2:0][5:0] in_prn_output = '0;
  logic [3:0][2:0] set_prn_ready = '0;
  logic [3:0][2:0][5:0] set_prn = '0;
  logic [3:0] iq_queue_ready = 4'hF;

  logic a_in_ready, b_in_ready;
  logic [3:0] a_iv, b_iv;
  logic [5:0] a_id, b_id;
  logic [31:0] a_instr, b_instr;
  logic [63:0] a_pc, b_pc;
  logic [2:0] a_piv, b_piv, a_pir, b_pir, a_pov, b_pov;
  logic [2:0][5:0] a_pi, b_pi, a_po, b_po;
  logic [31:0] a_stall, b_stall;
  logic a_err, b_err;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dispatch_steer #(.FU_CLASS('{0, 1, 0, 1})) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr),
    .in_pc(in_pc), .in_fu_class(in_fu_class),
    .in_prn_input_valid(in_prn_input_valid),
    .in_prn_input_ready(in_prn_input_ready),
    .in_prn_input(in_prn_input),
    .in_prn_output_valid(in_prn_output_valid),
    .in_prn_output(in_prn_output),
    .set_prn_ready(set_prn_ready), .set_prn(set_prn),
    .iq_queue_ready(iq_queue_ready),
    .iq_inst_valid(a_iv), .iq_inst_id(a_id),
    .iq_raw_instr(a_instr), .iq_pc(a_pc),
    .iq_prn_input_valid(a_piv),
    .iq_prn_input_ready(a_pir),
    .iq_prn_input(a_pi),
    .iq_prn_output_valid(a_pov),
    .iq_prn_output(a_po),
    .stall_cycles(a_stall), .err_no_fu(a_err)
  );

  dispatch_steer #(.FU_CLASS('{0, 0, 0, 0})) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr),
    .in_pc(in_pc), .in_fu_class(in_fu_class),
    .in_prn_input_valid(in_prn_input_valid),
    .in_prn_input_ready(in_prn_input_ready),
    .in_prn_input(in_prn_input),
    .in_prn_output_valid(in_prn_output_valid),
    .in_prn_output(in_prn_output),
    .set_prn_ready(set_prn_ready), .set_prn(set_prn),
    .iq_queue_ready(iq_queue_ready),
    .iq_inst_valid(b_iv), .iq_inst_id(b_id),
    .iq_raw_instr(b_instr), .iq_pc(b_pc),
    .iq_prn_input_valid(b_piv),
    .iq_prn_input_ready(b_pir),
    .iq_prn_input(b_pi),
    .iq_prn_output_valid(b_pov),
    .iq_prn_output(b_po),
    .stall_cycles(b_stall), .err_no_fu(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input int cls,
                       input logic [2:0] ov,
                       input logic [5:0] p0, input logic [5:0] p1,
                       input logic [5:0] p2);
    in_valid            = 1'b1;
    in_inst_id          = 6'(id);
    in_fu_class         = 2'(cls);
    in_raw_instr        = 32'h1300_0000 | 32'(id);
    in_pc               = 64'h8000_0000 + 64'(id) * 4;
    in_prn_input_valid  = ov;
    in_prn_input_ready  = '0;
    in_prn_input[0]     = p0;
    in_prn_input[1]     = p1;
    in_prn_input[2]     = p2;
    in_prn_output_valid = 3'b001;
    in_prn_output[0]    = 6'(id + 32);
    in_prn_output[1]    = '0;
    in_prn_output[2]    = '0;
  endtask

  initial begin
    // reset asserted mid-cycle, observed before any clock edge
    #3 rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_iv", 64'(a_iv), 64'd0);
    chk("rst_stall", 64'(a_stall), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // steer: class 0 on FU0/FU2, round-robin
    drive(1, 0, 3'b000, 0, 0, 0);
    #1;
    chk("lat_no_bypass", 64'(a_iv), 64'd0);
    chk("lat_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    drive(2, 0, 3'b000, 0, 0, 0);
    #1;
    chk("steer1_iv", 64'(a_iv), 64'b0001);
    chk("steer1_id", 64'(a_id), 64'd1);
    chk("steer1_pc", a_pc, 64'h8000_0004);
    chk("steer1_instr", 64'(a_instr), 64'h1300_0001);
    chk("steer1_out", 64'(a_po[0]), 64'd33);
    tick();
    drive(3, 0, 3'b000, 0, 0, 0);
    #1;
    chk("steer2_iv", 64'(a_iv), 64'b0100);
    chk("steer2_id", 64'(a_id), 64'd2);
    tick();
    drive(4, 0, 3'b000, 0, 0, 0);
    #1;
    chk("steer3_iv", 64'(a_iv), 64'b0001);
    chk("steer3_id", 64'(a_id), 64'd3);
    tick();
    in_valid = 1'b0;
    #1;
    chk("steer4_iv", 64'(a_iv), 64'b0100);
    chk("steer4_id", 64'(a_id), 64'd4);
    tick();
    #1;
    chk("steer_empty_iv", 64'(a_iv), 64'd0);
    chk("steer_stall", 64'(a_stall), 64'd0);

    // backpressure
    iq_queue_ready = 4'h0;
    drive(10, 0, 3'b000, 0, 0, 0);
    #1;
    chk("bp_ready0", 64'(a_in_ready), 64'd1);
    tick();
    drive(11, 0, 3'b000, 0, 0, 0);
    #1;
    chk("bp_ready1", 64'(a_in_ready), 64'd1);
    chk("bp_iv1", 64'(a_iv), 64'd0);
    tick();
    drive(12, 0, 3'b000, 0, 0, 0);
    #1;
    chk("bp_full", 64'(a_in_ready), 64'd0);
    chk("bp_stall1", 64'(a_stall), 64'd1);
    tick();
    iq_queue_ready = 4'hF;
    #1;
    chk("bp_stall2", 64'(a_stall), 64'd2);
    chk("bp_full_hold", 64'(a_in_ready), 64'd0);
    chk("bp_rel_iv", 64'(a_iv), 64'b0001);
    chk("bp_rel_id", 64'(a_id), 64'd10);
    tick();
    #1;
    chk("bp_id11", 64'(a_id), 64'd11);
    chk("bp_iv11", 64'(a_iv), 64'b0100);
    chk("bp_ready_back", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_id12", 64'(a_id), 64'd12);
    chk("bp_iv12", 64'(a_iv), 64'b0001);
    tick();
    #1;
    chk("empty_iv", 64'(a_iv), 64'd0);
    chk("empty_id", 64'(a_id), 64'd0);
    chk("empty_pc", a_pc, 64'd0);
    chk("bp_stall_end", 64'(a_stall), 64'd2);

    // wakeup while buffered
    iq_queue_ready = 4'h0;
    drive(20, 1, 3'b001, 5, 0, 0);
    tick();
    in_valid = 1'b0;
    set_prn_ready[1][2] = 1'b1;
    set_prn[1][2] = 6'd5;
    #1;
    chk("wk_bypass_q", 64'(a_pir), 64'b001);
    chk("wk_hold_iv", 64'(a_iv), 64'd0);
    tick();
    set_prn_ready = '0;
    set_prn = '0;
    iq_queue_ready = 4'hF;
    #1;
    chk("wk_stored", 64'(a_pir), 64'b001);
    chk("wk_iv", 64'(a_iv), 64'b0010);
    chk("wk_id", 64'(a_id), 64'd20);
    tick();

    // wakeup in dispatch cycle, invalid operand never ready
    iq_queue_ready = 4'h0;
    drive(21, 1, 3'b011, 7, 9, 7);
    tick();
    in_valid = 1'b0;
    #1;
    chk("wk2_pre", 64'(a_pir), 64'b000);
    iq_queue_ready = 4'hF;
    set_prn_ready[0][0] = 1'b1;
    set_prn[0][0] = 6'd7;
    #1;
    chk("wk2_iv", 64'(a_iv), 64'b1000);
    chk("wk2_bypass", 64'(a_pir), 64'b001);
    chk("wk2_valid", 64'(a_piv), 64'b011);
    tick();

    // wakeup coinciding with the push
    set_prn_ready = '0;
    set_prn = '0;
    iq_queue_ready = 4'h0;
    drive(22, 1, 3'b001, 11, 0, 0);
    set_prn_ready[3][1] = 1'b1;
    set_prn[3][1] = 6'd11;
    tick();
    set_prn_ready = '0;
    set_prn = '0;
    in_valid = 1'b0;
    iq_queue_ready = 4'hF;
    #1;
    chk("wk3_iv", 64'(a_iv), 64'b0010);
    chk("wk3_ready", 64'(a_pir), 64'b001);
    tick();

    // flush with two buffered plus a valid push
    iq_queue_ready = 4'h0;
    drive(30, 0, 3'b000, 0, 0, 0);
    tick();
    drive(31, 0, 3'b000, 0, 0, 0);
    tick();
    drive(32, 0, 3'b000, 0, 0, 0);
    flush = 1'b1;
    iq_queue_ready = 4'hF;
    #1;
    chk("fl_iv", 64'(a_iv), 64'd0);
    chk("fl_in_ready", 64'(a_in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_empty_iv", 64'(a_iv), 64'd0);
    chk("fl_empty_ready", 64'(a_in_ready), 64'd1);
    chk("fl_stall", 64'(a_stall), 64'd4);
    drive(33, 0, 3'b000, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fl_rr_iv", 64'(a_iv), 64'b0100);
    chk("fl_rr_id", 64'(a_id), 64'd33);
    tick();

    // class with no FU
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("bad_err_clr", 64'(b_err), 64'd0);
    drive(40, 3, 3'b000, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bad_iv0", 64'(b_iv), 64'd0);
    chk("bad_err0", 64'(b_err), 64'd0);
    tick();
    #1;
    chk("bad_err1", 64'(b_err), 64'd1);
    chk("bad_iv1", 64'(b_iv), 64'd0);
    chk("bad_err_a", 64'(a_err), 64'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("bad_fl_iv", 64'(a_iv), 64'd0);
    chk("bad_fl_ready", 64'(a_in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("bad_sticky", 64'(b_err), 64'd1);
    chk("bad_empty", 64'(b_in_ready), 64'd1);

    // reset mid-operation with a class-0 entry pending
    iq_queue_ready = 4'h0;
    drive(42, 0, 3'b000, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    iq_queue_ready = 4'hF;
    #1;
    chk("mid_pre_iv", 64'(a_iv), 64'b0001);
    rst = 1'b1;
    #1;
    chk("mid_iv", 64'(a_iv), 64'd0);
    chk("mid_ready", 64'(a_in_ready), 64'd1);
    chk("mid_err_b", 64'(b_err), 64'd0);
    chk("mid_stall", 64'(a_stall), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
